// File: rtl/board_disp_tx.sv
// board_disp_tx -- transmit end of the board interface.
//
// Serialises a BOARD_W-bit board word, MSB first, to an external
// shift-register LED driver as data / clock / latch. The block is
// double-buffered: a word loaded while a frame is in flight is parked in a
// shadow register and sent right after the current frame. If a second word
// arrives before the parked one was sent, the last word wins and overrun
// pulses.
//
// Optional feature (macro BOARD_DISP_PARITY_EN): one extra odd-parity bit
// (~^ of the word) is shifted after the data bits, before the latch.
//
// Ports:
//   in_clka     system clock, rising edge
//   in_restart  asynchronous reset, active-high
//   board_in    board word to transmit
//   board_load  one-cycle strobe, board_in valid
//   ser_data    serial data, MSB first
//   ser_clk     serial clock, driver samples on its rising edge
//   ser_latch   latch pulse after the last bit of a frame
//   busy        high while a frame is in progress
//   frame_done  one-cycle pulse after each frame completes
//   overrun     one-cycle pulse when an unsent pending word is overwritten
module board_disp_tx #(
  parameter int CLK_DIV = 2,
  parameter int BOARD_W = 32
) (
  input  logic               in_clka,
  input  logic               in_restart,
  input  logic [BOARD_W-1:0] board_in,
  input  logic               board_load,
  output logic               ser_data,
  output logic               ser_clk,
  output logic               ser_latch,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun
);

`ifdef BOARD_DISP_PARITY_EN
  localparam int NBITS = BOARD_W + 1;
`else
  localparam int NBITS = BOARD_W;
`endif
  localparam int BCW = $clog2(BOARD_W + 1);
  localparam int DCW = $clog2(CLK_DIV + 1);

  typedef enum logic [1:0] {IDLE, SETUP, HOLD, LATCH} state_t;

  state_t             state, state_nxt;
  logic [NBITS-1:0]   shreg, shadow;
  logic               pending;
  logic [BCW-1:0]     bit_cnt;
  logic [DCW-1:0]     div_cnt;
  logic               div_end, last_bit, frame_end, busy_load;

  // Word as it goes on the wire: data bits, then the parity bit if enabled.
  function automatic logic [NBITS-1:0] frame_word(input logic [BOARD_W-1:0] w);
`ifdef BOARD_DISP_PARITY_EN
    return {w, ~^w};
`else
    return w;
`endif
  endfunction

  assign div_end   = (div_cnt == DCW'(CLK_DIV - 1));
  assign last_bit  = (bit_cnt == BCW'(NBITS - 1));
  assign frame_end = (state == LATCH) && div_end;
  // Any load outside IDLE, including the final LATCH cycle, is a busy load.
  assign busy_load = board_load && (state != IDLE);

  always_ff @(posedge in_clka or posedge in_restart) begin
    if (in_restart) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ser_clk   = 1'b0;
    ser_latch = 1'b0;
    ser_data  = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (board_load) state_nxt = SETUP;
      end
      SETUP: begin
        ser_data = shreg[NBITS-1];
        if (div_end) state_nxt = HOLD;
      end
      HOLD: begin
        ser_clk  = 1'b1;
        ser_data = shreg[NBITS-1];
        if (div_end) state_nxt = last_bit ? LATCH : SETUP;
      end
      LATCH: begin
        ser_latch = 1'b1;
        // A load in the final latch cycle is forwarded straight to SETUP.
        if (div_end) state_nxt = (pending || board_load) ? SETUP : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge in_clka or posedge in_restart) begin
    if (in_restart) begin
      shreg      <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= frame_end;
      // A busy load with a word still pending always discards that word,
      // whether it lands in the shadow or is forwarded at the frame end.
      overrun    <= busy_load && pending;

      if (state == IDLE || div_end) div_cnt <= '0;
      else                          div_cnt <= div_cnt + DCW'(1);

      if (busy_load && !frame_end) begin
        shadow  <= frame_word(board_in);
        pending <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end

      unique case (state)
        IDLE: if (board_load) begin
          shreg   <= frame_word(board_in);
          bit_cnt <= '0;
        end
        HOLD: if (div_end) begin
          shreg   <= {shreg[NBITS-2:0], 1'b0};
          bit_cnt <= bit_cnt + BCW'(1);
        end
        LATCH: if (div_end) begin
          bit_cnt <= '0;
          if (board_load)   shreg <= frame_word(board_in);
          else if (pending) shreg <= shadow;
        end
        default: ;
      endcase
    end
  end

endmodule
